// File: rtl/input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : input_conditioner                                          |
// | Description : Board input front end. Synchronizes the slide switches,    |
// |               synchronizes and debounces four active-low push buttons,   |
// |               emits per-key press/release pulses and keeps a display     |
// |               signed/unsigned mode bit toggled by KEY[0].                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 10
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic [3:0]          KEY,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic [3:0]          key_level,
  output logic [3:0]          key_press,
  output logic [3:0]          key_release,
  output logic                signed_mode
);

  // Counter is just wide enough to hold DEBOUNCE_CYCLES-1, so it never wraps.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int NUM_KEYS = 4;

  // Per-key debounce state: IDLE_EQUAL always carries a zero count.
  typedef enum logic [0:0] {
    IDLE_EQUAL = 1'b0,
    COUNTING   = 1'b1
  } key_state_t;

  // ------------------------------------------------------------------------
  // Switch synchronizer: two flops per bit, no debounce.
  // ------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_meta_q;
  logic [SW_WIDTH-1:0] sw_sync_q;

  // Two-stage synchronizer for the slide switches.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_sync = sw_sync_q;

  // ------------------------------------------------------------------------
  // Key synchronizer: inverted first so the whole pipeline is 1 = pressed.
  // ------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_meta_q;
  logic [NUM_KEYS-1:0] key_sync_q;

  // Two-stage synchronizer for the keys, converted to pressed-high.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      key_meta_q <= '0;
      key_sync_q <= '0;
    end else begin
      key_meta_q <= ~KEY;
      key_sync_q <= key_meta_q;
    end
  end

  // ------------------------------------------------------------------------
  // Independent debouncer per key.
  // ------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             k_sync;

    assign k_sync = key_sync_q[gi];

    // Debounce state, count, accepted level and edge pulses.
    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        state_q   <= IDLE_EQUAL;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Next-state: count while the synchronized input disagrees with the
    // accepted level, accept on the DEBOUNCE_CYCLES-th disagreeing edge,
    // and restart from zero whenever the input agrees again.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE_EQUAL: begin
          cnt_d = '0;
          if (k_sync != level_q) begin
            // DEBOUNCE_CYCLES >= 2, so the first disagreeing edge only counts.
            cnt_d   = CNT_W'(1);
            state_d = COUNTING;
          end
        end
        COUNTING: begin
          if (k_sync == level_q) begin
            cnt_d   = '0;
            state_d = IDLE_EQUAL;
          end else if (cnt_q == CNT_MAX) begin
            level_d   = k_sync;
            press_d   = k_sync;
            release_d = ~k_sync;
            cnt_d     = '0;
            state_d   = IDLE_EQUAL;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = COUNTING;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE_EQUAL;
        end
      endcase
    end

    assign key_level[gi]   = level_q;
    assign key_press[gi]   = press_q;
    assign key_release[gi] = release_q;
  end : g_key

  // ------------------------------------------------------------------------
  // Display mode: one toggle per debounced press of KEY[0].
  // ------------------------------------------------------------------------
  logic signed_mode_q;

  // Toggle on the edge following a KEY[0] press pulse.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      signed_mode_q <= 1'b0;
    end else begin
      signed_mode_q <= signed_mode_q ^ key_press[0];
    end
  end

  assign signed_mode = signed_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_input_conditioner                                       |
// | Description : Self-checking bench for input_conditioner with a           |
// |               behavioural reference model and randomized key/switch      |
// |               stimulus.                                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_input_conditioner;

  localparam int DEB = 4;
  localparam int SWW = 10;

  logic           CLOCK_50 = 1'b0;
  logic           rst      = 1'b1;
  logic [3:0]     KEY      = 4'hF;
  logic [SWW-1:0] SW       = '0;
  logic [SWW-1:0] sw_sync;
  logic [3:0]     key_level;
  logic [3:0]     key_press;
  logic [3:0]     key_release;
  logic           signed_mode;

  int n_checks = 0;
  int n_pass   = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SW_WIDTH       (SWW)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .KEY        (KEY),
    .SW         (SW),
    .sw_sync    (sw_sync),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .signed_mode(signed_mode)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: a 2-deep input pipeline, and a run length of how many
  // consecutive edges each synchronized key has disagreed with its level.
  logic [SWW-1:0] m_w1 = '0, m_w2 = '0;
  logic [3:0]     m_s1 = '0, m_s2 = '0;
  logic [3:0]     m_lvl = '0, m_prs = '0, m_rel = '0;
  logic           m_sgn = 1'b0;
  int             m_run [4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step();
    logic [3:0] np;
    logic [3:0] nr;
    np = '0;
    nr = '0;
    if (rst) begin
      m_w1 = '0; m_w2 = '0; m_s1 = '0; m_s2 = '0;
      m_lvl = '0; m_prs = '0; m_rel = '0; m_sgn = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      m_sgn = m_sgn ^ m_prs[0];
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_lvl[i] = m_s2[i];
            np[i]    = m_s2[i];
            nr[i]    = ~m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_prs = np;
      m_rel = nr;
      m_s2 = m_s1;
      m_s1 = ~KEY;
      m_w2 = m_w1;
      m_w1 = SW;
    end
  endtask

  // One clock edge: advance the model, then compare every output.
  task automatic tick();
    model_step();
    @(posedge CLOCK_50);
    #1;
    check("sw_sync",     32'(sw_sync),     32'(m_w2));
    check("key_level",   32'(key_level),   32'(m_lvl));
    check("key_press",   32'(key_press),   32'(m_prs));
    check("key_release", 32'(key_release), 32'(m_rel));
    check("signed_mode", 32'(signed_mode), 32'(m_sgn));
    check("press_and_release", 32'(key_press & key_release), 32'h0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hold;
    // Reset
    rst = 1'b1; KEY = 4'hF; SW = '0;
    ticks(3);
    check("reset_outputs", 32'({sw_sync, key_level, key_press, key_release, signed_mode}), 32'h0);

    // Switch latency and a steady KEY[0] press
    rst = 1'b0; SW = 10'h3FF; KEY = 4'b1110;
    tick();                                             // edge 1
    check("sw_sync_edge1", 32'(sw_sync), 32'h0);
    tick();                                             // edge 2
    check("sw_sync_edge2", 32'(sw_sync), 32'h3FF);
    ticks(3);                                           // edges 3..5
    check("level0_edge5", 32'(key_level[0]), 32'h0);
    tick();                                             // edge 6
    check("level0_edge6", 32'(key_level[0]), 32'h1);
    check("press0_edge6", 32'(key_press[0]), 32'h1);
    check("signed_edge6", 32'(signed_mode), 32'h0);
    tick();                                             // edge 7
    check("signed_edge7", 32'(signed_mode), 32'h1);
    check("press0_edge7", 32'(key_press[0]), 32'h0);
    ticks(3);                                           // held 10 cycles total

    // Release then press again
    KEY = 4'hF;
    ticks(10);
    check("level0_released", 32'(key_level[0]), 32'h0);
    check("signed_after_release", 32'(signed_mode), 32'h1);
    KEY = 4'b1110;
    ticks(10);
    check("signed_second_press", 32'(signed_mode), 32'h0);
    KEY = 4'hF;
    ticks(10);

    // Glitch of 3 cycles on KEY[0]
    KEY = 4'b1110;
    ticks(3);
    KEY = 4'hF;
    ticks(10);
    check("glitch_level", 32'(key_level[0]), 32'h0);
    check("glitch_signed", 32'(signed_mode), 32'h0);

    // Reset during a KEY[1] press
    KEY = 4'b1101;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(5);
    check("level1_before_accept", 32'(key_level[1]), 32'h0);
    tick();
    check("level1_after_reset", 32'(key_level[1]), 32'h1);
    check("signed_after_key1", 32'(signed_mode), 32'h0);
    ticks(4);
    KEY = 4'hF;
    ticks(10);

    // All four keys together
    KEY = 4'b0000;
    ticks(5);
    tick();
    check("all_press", 32'(key_press), 32'hF);
    check("all_level", 32'(key_level), 32'hF);
    tick();
    check("all_signed", 32'(signed_mode), 32'h1);
    ticks(6);
    KEY = 4'hF;
    ticks(10);

    // Randomized stretches of key activity, switch noise and occasional reset
    for (int n = 0; n < 400; n++) begin
      KEY  = 4'($urandom);
      hold = $urandom_range(1, 9);
      for (int c = 0; c < hold; c++) begin
        SW  = SWW'($urandom);
        rst = ($urandom_range(0, 149) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
